// File: rtl/hazard_controller_pkg.sv
// Shared encodings and the stage-control bundle for the pipeline hazard controller.
package hazard_controller_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MD_WAIT  = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_flush;
      logic ex_mem_write;
      logic ex_mem_flush;
      logic mem_wb_write;
   } stage_ctl_t;

   localparam stage_ctl_t CTL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
      id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1, ex_mem_flush: 1'b0, mem_wb_write: 1'b1};
   localparam stage_ctl_t CTL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
      id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0, ex_mem_flush: 1'b0, mem_wb_write: 1'b0};
   // Front end held while EX is occupied; EX/MEM takes bubbles until the result is ready.
   localparam stage_ctl_t CTL_MD_HOLD = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
      id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b1, ex_mem_flush: 1'b1, mem_wb_write: 1'b1};
   localparam stage_ctl_t CTL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
      id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1, ex_mem_flush: 1'b0, mem_wb_write: 1'b1};
   localparam stage_ctl_t CTL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
      id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1, ex_mem_flush: 1'b0, mem_wb_write: 1'b1};

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard inputs from the pipeline stages and the stage/mul-div controls returned to them.
interface hazard_controller_if;
   logic [4:0] IF_ID_Read_register1;
   logic [4:0] IF_ID_Read_register2;
   logic       IF_ID_UseRs1;
   logic       IF_ID_UseRs2;
   logic       ID_EX_MemRead;
   logic [4:0] ID_EX_Write_register;
   logic       ID_EX_MulDiv;
   logic       EX_BranchTaken;
   logic       EX_MEM_MemAccess;
   logic       dmem_ready;
   logic       md_done;
   logic       PC_Write;
   logic       IF_ID_Write;
   logic       IF_ID_Flush;
   logic       ID_EX_Write;
   logic       ID_EX_Flush;
   logic       EX_MEM_Write;
   logic       EX_MEM_Flush;
   logic       MEM_WB_Write;
   logic       md_start;

   modport master (
      output IF_ID_Read_register1, IF_ID_Read_register2, IF_ID_UseRs1, IF_ID_UseRs2,
             ID_EX_MemRead, ID_EX_Write_register, ID_EX_MulDiv, EX_BranchTaken,
             EX_MEM_MemAccess, dmem_ready, md_done,
      input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
             EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write, md_start
   );

   modport slave (
      input  IF_ID_Read_register1, IF_ID_Read_register2, IF_ID_UseRs1, IF_ID_UseRs2,
             ID_EX_MemRead, ID_EX_Write_register, ID_EX_MulDiv, EX_BranchTaken,
             EX_MEM_MemAccess, dmem_ready, md_done,
      output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
             EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write, md_start
   );
endinterface

// File: rtl/hazard_controller_load_use_detect.sv
// Combinational load-use check: a load in EX whose rd is read by the instruction in ID.
module hazard_controller_load_use_detect
   import hazard_controller_pkg::*;
(
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       use_rs1,
   input  logic       use_rs2,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   output logic       hazard
);
   // x0 is never written, so a load targeting it cannot create a dependency.
   assign hazard = ex_mem_read && (ex_rd != REG_X0) &&
                   ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing FSM: memory freezes, mul/div occupancy, branch flushes and load-use stalls.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   hazard_controller_if.slave hz,
   output logic             md_error,
   output logic [CNT_W-1:0] stall_count
);
   localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

   logic [1:0]    state;
   logic [TW-1:0] tcnt;
   logic          md_issued;
   logic          done_seen;
   logic          mem_wait, load_use, md_go, md_release;
   stage_ctl_t    ctl;
   logic          start;

   hazard_controller_load_use_detect u_lud (
      .rs1         (hz.IF_ID_Read_register1),
      .rs2         (hz.IF_ID_Read_register2),
      .use_rs1     (hz.IF_ID_UseRs1),
      .use_rs2     (hz.IF_ID_UseRs2),
      .ex_mem_read (hz.ID_EX_MemRead),
      .ex_rd       (hz.ID_EX_Write_register),
      .hazard      (load_use)
   );

   assign mem_wait   = hz.EX_MEM_MemAccess & ~hz.dmem_ready;
   assign md_go      = hz.ID_EX_MulDiv & ~md_issued;
   assign md_release = hz.md_done | done_seen | (tcnt == TW'(MD_TIMEOUT - 1));

   always_comb begin
      ctl   = CTL_NORMAL;
      start = 1'b0;
      if (rst_n) begin
         if (mem_wait) begin
            ctl = CTL_FREEZE;
         end else if (state == ST_MD_WAIT) begin
            if (!md_release) ctl = CTL_MD_HOLD;
         end else if (md_go) begin
            ctl   = CTL_MD_HOLD;
            start = 1'b1;
         end else if (hz.EX_BranchTaken) begin
            ctl = CTL_BRANCH;
         end else if (load_use) begin
            ctl = CTL_LOAD_USE;
         end
      end
   end

   assign hz.PC_Write     = ctl.pc_write;
   assign hz.IF_ID_Write  = ctl.if_id_write;
   assign hz.IF_ID_Flush  = ctl.if_id_flush;
   assign hz.ID_EX_Write  = ctl.id_ex_write;
   assign hz.ID_EX_Flush  = ctl.id_ex_flush;
   assign hz.EX_MEM_Write = ctl.ex_mem_write;
   assign hz.EX_MEM_Flush = ctl.ex_mem_flush;
   assign hz.MEM_WB_Write = ctl.mem_wb_write;
   assign hz.md_start     = start;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         tcnt        <= '0;
         md_issued   <= 1'b0;
         done_seen   <= 1'b0;
         md_error    <= 1'b0;
         stall_count <= '0;
      end else begin
         if (!ctl.pc_write && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);

         if (state == ST_MD_WAIT) begin
            // The timeout only runs while the mul/div is what holds the pipeline.
            if (mem_wait) begin
               done_seen <= done_seen | hz.md_done;
            end else if (md_release) begin
               state     <= ST_RUN;
               md_issued <= 1'b1;
               done_seen <= 1'b0;
               if (!hz.md_done && !done_seen) md_error <= 1'b1;
            end else begin
               tcnt <= tcnt + TW'(1);
            end
         end else if (mem_wait) begin
            state <= ST_MEM_WAIT;
         end else if (md_go) begin
            state <= ST_MD_WAIT;
            tcnt  <= '0;
         end else begin
            // ID/EX advances here, so a completed mul/div has left EX.
            state     <= ST_RUN;
            md_issued <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: vector table, directed multi-cycle sequences, random vs reference model.
module tb_hazard_controller;
   localparam int TO    = 8;
   localparam int CNT_W = 4;

   // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write, md_start}
   localparam logic [8:0] A_NORMAL  = 9'b110101010;
   localparam logic [8:0] A_LOADUSE = 9'b000111010;
   localparam logic [8:0] A_BRANCH  = 9'b111111010;
   localparam logic [8:0] A_FREEZE  = 9'b000000000;
   localparam logic [8:0] A_MDHOLD  = 9'b000001110;
   localparam logic [8:0] A_MDSTART = 9'b000001111;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      bit u1, u2, mr, md, br, ma, rdy, done;
   } in_t;

   typedef struct {
      in_t        in;
      logic [8:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic md_error;
   logic [CNT_W-1:0] stall_count;
   int checks = 0;
   int errors = 0;

   // Reference model: which operation occupies the pipeline, how long it has waited.
   bit m_busy, m_pend, m_issued, m_err;
   int m_waited, m_stalls;

   hazard_controller_if ifc ();

   hazard_controller #(.MD_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hz          (ifc),
      .md_error    (md_error),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   function automatic in_t mk(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                              input bit mr, input logic [4:0] rd, input bit md, input bit br,
                              input bit ma, input bit rdy, input bit done);
      in_t v;
      v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.mr = mr; v.rd = rd;
      v.md = md; v.br = br; v.ma = ma; v.rdy = rdy; v.done = done;
      return v;
   endfunction

   function automatic logic [8:0] dut_ctl();
      return {ifc.PC_Write, ifc.IF_ID_Write, ifc.IF_ID_Flush, ifc.ID_EX_Write, ifc.ID_EX_Flush,
              ifc.EX_MEM_Write, ifc.EX_MEM_Flush, ifc.MEM_WB_Write, ifc.md_start};
   endfunction

   function automatic logic [8:0] model_ctl(input in_t v);
      bit mw = v.ma && !v.rdy;
      bit lu = v.mr && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
      if (mw) return A_FREEZE;
      if (m_busy) return (v.done || m_pend || m_waited == TO - 1) ? A_NORMAL : A_MDHOLD;
      if (v.md && !m_issued) return A_MDSTART;
      if (v.br) return A_BRANCH;
      if (lu) return A_LOADUSE;
      return A_NORMAL;
   endfunction

   task automatic model_update(input in_t v, input logic [8:0] act);
      bit mw = v.ma && !v.rdy;
      if (!act[8] && m_stalls < (1 << CNT_W) - 1) m_stalls++;
      if (m_busy) begin
         if (mw) m_pend = m_pend | v.done;
         else if (v.done || m_pend) begin m_busy = 0; m_issued = 1; m_pend = 0; end
         else if (m_waited == TO - 1) begin m_busy = 0; m_issued = 1; m_err = 1; end
         else m_waited++;
      end else if (!mw) begin
         if (v.md && !m_issued) begin m_busy = 1; m_waited = 0; end
         else m_issued = 0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic apply(input in_t v);
      ifc.IF_ID_Read_register1 = v.rs1;
      ifc.IF_ID_Read_register2 = v.rs2;
      ifc.IF_ID_UseRs1         = v.u1;
      ifc.IF_ID_UseRs2         = v.u2;
      ifc.ID_EX_MemRead        = v.mr;
      ifc.ID_EX_Write_register = v.rd;
      ifc.ID_EX_MulDiv         = v.md;
      ifc.EX_BranchTaken       = v.br;
      ifc.EX_MEM_MemAccess     = v.ma;
      ifc.dmem_ready           = v.rdy;
      ifc.md_done              = v.done;
   endtask

   // One clock: drive, sample mid-cycle, compare with the model (and a hand value if given).
   task automatic step(input in_t v, input bit hand, input logic [8:0] hexp, input string nm);
      logic [8:0] got, mexp;
      apply(v);
      @(negedge clk);
      got  = dut_ctl();
      mexp = model_ctl(v);
      chk({nm, "/ctl"}, 32'(got), 32'(mexp));
      if (hand) chk({nm, "/hand"}, 32'(got), 32'(hexp));
      chk({nm, "/md_error"}, 32'(md_error), 32'(m_err));
      chk({nm, "/stall_count"}, 32'(stall_count), 32'(m_stalls));
      model_update(v, mexp);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input in_t v);
      apply(v);
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset/ctl", 32'(dut_ctl()), 32'(A_NORMAL));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_busy = 0; m_pend = 0; m_issued = 0; m_err = 0; m_waited = 0; m_stalls = 0;
      chk("reset/md_error", 32'(md_error), 32'd0);
      chk("reset/stall_count", 32'(stall_count), 32'd0);
   endtask

   in_t  idle, lw_hit, mdv;
   vec_t tbl[11];

   initial begin
      idle   = mk(5'd1, 0, 5'd2, 0, 0, 5'd0, 0, 0, 0, 1, 0);
      lw_hit = mk(5'd5, 1, 5'd9, 0, 1, 5'd5, 0, 0, 0, 1, 0);
      tbl[0]  = '{lw_hit, A_LOADUSE};
      tbl[1]  = '{mk(5'd0, 1, 5'd0, 0, 1, 5'd0, 0, 0, 0, 1, 0), A_NORMAL};
      tbl[2]  = '{mk(5'd5, 0, 5'd9, 0, 1, 5'd5, 0, 0, 0, 1, 0), A_NORMAL};
      tbl[3]  = '{mk(5'd3, 1, 5'd7, 1, 1, 5'd7, 0, 0, 0, 1, 0), A_LOADUSE};
      tbl[4]  = '{mk(5'd3, 1, 5'd7, 0, 1, 5'd7, 0, 0, 0, 1, 0), A_NORMAL};
      tbl[5]  = '{mk(5'd5, 1, 5'd5, 1, 0, 5'd5, 0, 0, 0, 1, 0), A_NORMAL};
      tbl[6]  = '{mk(5'd5, 1, 5'd9, 0, 1, 5'd5, 0, 1, 0, 1, 0), A_BRANCH};
      tbl[7]  = '{mk(5'd1, 0, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 0), A_BRANCH};
      tbl[8]  = '{mk(5'd1, 0, 5'd2, 0, 0, 5'd0, 0, 0, 1, 1, 0), A_NORMAL};
      tbl[9]  = '{mk(5'd1, 0, 5'd2, 0, 0, 5'd0, 0, 1, 1, 0, 0), A_FREEZE};
      tbl[10] = '{mk(5'd1, 0, 5'd2, 0, 0, 5'd0, 0, 0, 1, 1, 0), A_NORMAL};

      // Reset with hazards present: controls must be forced to normal.
      do_reset(lw_hit);
      foreach (tbl[i]) step(tbl[i].in, 1, tbl[i].exp, $sformatf("tbl%0d", i));

      // Mul/div completing after five cycles, then still visible in EX for one more.
      do_reset(idle);
      mdv = idle; mdv.md = 1;
      step(mdv, 1, A_MDSTART, "md_start");
      for (int i = 0; i < 4; i++) step(mdv, 1, A_MDHOLD, "md_hold");
      mdv.done = 1;
      step(mdv, 1, A_NORMAL, "md_done");
      mdv.done = 0;
      step(mdv, 1, A_NORMAL, "md_no_restart");
      step(idle, 1, A_NORMAL, "md_after");
      chk("md/stall_count", 32'(stall_count), 32'd5);

      // Data memory wait with a branch pending: frozen, then the branch acts on release.
      do_reset(idle);
      for (int i = 0; i < 3; i++) step(mk(5'd1, 0, 5'd2, 0, 0, 5'd0, 0, 1, 1, 0, 0), 1, A_FREEZE, "mem_freeze");
      step(mk(5'd1, 0, 5'd2, 0, 0, 5'd0, 0, 1, 1, 1, 0), 1, A_BRANCH, "mem_release");
      chk("mem/stall_count", 32'(stall_count), 32'd3);

      // md_done arriving during a memory freeze is remembered.
      do_reset(idle);
      mdv = idle; mdv.md = 1;
      step(mdv, 1, A_MDSTART, "mdm_start");
      step(mdv, 1, A_MDHOLD, "mdm_hold");
      mdv.ma = 1; mdv.rdy = 0; mdv.done = 1;
      step(mdv, 1, A_FREEZE, "mdm_freeze_done");
      mdv.done = 0;
      step(mdv, 1, A_FREEZE, "mdm_freeze");
      mdv.ma = 0; mdv.rdy = 1;
      step(mdv, 1, A_NORMAL, "mdm_release");
      step(idle, 1, A_NORMAL, "mdm_after");

      // Timeout with md_done never arriving.
      do_reset(idle);
      mdv = idle; mdv.md = 1;
      step(mdv, 1, A_MDSTART, "to_start");
      for (int i = 0; i < TO - 1; i++) step(mdv, 1, A_MDHOLD, "to_hold");
      step(mdv, 1, A_NORMAL, "to_release");
      chk("to/md_error", 32'(md_error), 32'd1);
      step(idle, 1, A_NORMAL, "to_after");

      // Reset in the middle of a mul/div wait.
      step(mdv, 1, A_MDSTART, "rst_md_start");
      for (int i = 0; i < 3; i++) step(mdv, 1, A_MDHOLD, "rst_md_hold");
      do_reset(mdv);
      step(idle, 1, A_NORMAL, "rst_md_after");

      // Long freeze: counter saturates at all-ones.
      for (int i = 0; i < 20; i++) step(mk(5'd1, 0, 5'd2, 0, 0, 5'd0, 0, 0, 1, 0, 0), 0, A_FREEZE, "sat");
      chk("sat/stall_count", 32'(stall_count), 32'd15);

      do_reset(idle);
      for (int n = 0; n < 600; n++) begin
         in_t v;
         v.rs1  = 5'($urandom_range(0, 3));
         v.rs2  = 5'($urandom_range(0, 3));
         v.rd   = 5'($urandom_range(0, 3));
         v.u1   = ($urandom_range(0, 99) < 60);
         v.u2   = ($urandom_range(0, 99) < 60);
         v.mr   = ($urandom_range(0, 99) < 50);
         v.md   = ($urandom_range(0, 99) < 15);
         v.br   = ($urandom_range(0, 99) < 15);
         v.ma   = ($urandom_range(0, 99) < 30);
         v.rdy  = ($urandom_range(0, 99) < 60);
         v.done = ($urandom_range(0, 99) < 12);
         if ($urandom_range(0, 199) == 0) do_reset(v);
         else step(v, 0, A_NORMAL, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It pairs with the EX-stage forwarding logic and resolves every hazard that forwarding cannot: load-use stalls, multi-cycle mul/div occupancy of EX, data-memory wait states and taken-branch flushes. It drives the per-stage write-enable and flush controls and performs the start/done handshake with the mul/div unit.

Parameters:
MD_TIMEOUT, 64, max cycles in MD_WAIT before md_error asserts and the op is abandoned
CNT_W, 16, width of stall_count performance counter (saturating)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
IF_ID_Read_register1  input  5  rs1 of instruction in ID
IF_ID_Read_register2  input  5  rs2 of instruction in ID
IF_ID_UseRs1  input  1  ID instruction reads rs1
IF_ID_UseRs2  input  1  ID instruction reads rs2
ID_EX_MemRead  input  1  EX instruction is a load
ID_EX_Write_register  input  5  rd of EX instruction
ID_EX_MulDiv  input  1  EX instruction is mul/div
EX_BranchTaken  input  1  EX resolved taken branch/jump
EX_MEM_MemAccess  input  1  MEM instruction accesses data memory
dmem_ready  input  1  data memory completes access this cycle
md_done  input  1  mul/div result valid (1-cycle pulse)
PC_Write  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register enable
IF_ID_Flush  output  1  load NOP into IF/ID
ID_EX_Write  output  1  ID/EX register enable
ID_EX_Flush  output  1  load bubble into ID/EX
EX_MEM_Write  output  1  EX/MEM register enable
EX_MEM_Flush  output  1  load bubble into EX/MEM
MEM_WB_Write  output  1  MEM/WB register enable
md_start  output  1  1-cycle start pulse to mul/div unit
md_error  output  1  sticky timeout flag
stall_count  output  CNT_W  cycles with PC_Write=0, saturating

Behaviour:
- States: RUN, MD_WAIT, MEM_WAIT. Reset (rst_n=0 at edge): state=RUN, md_error=0, stall_count=0, internal timeout counter=0; while reset is asserted md_start=0 and all Write enables forced 1, Flushes 0.
- Priority per cycle (highest first): mem wait > mul/div > branch flush > load-use > normal.
- mem_wait = EX_MEM_MemAccess & ~dmem_ready. In RUN or MEM_WAIT with mem_wait: PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write = 0; MEM_WB_Flush not provided, so MEM_WB_Write=0 as well (full freeze); state->MEM_WAIT. Leaves to RUN the cycle dmem_ready=1 (enables 1 that cycle).
- RUN with ID_EX_MulDiv (no mem_wait): md_start=1 for exactly this cycle, PC/IF_ID/ID_EX Write=0, EX_MEM_Flush=1; state->MD_WAIT, timeout counter cleared.
- MD_WAIT: md_start=0, same holds/bubble; counter increments. On md_done: EX_MEM_Write=1 with no flush (result captured), all enables 1, state->RUN, and the same mul/div must not restart (internal md_issued bit blocks md_start until ID_EX advances). Counter reaching MD_TIMEOUT-1 without md_done: md_error<=1 (sticky until reset), release as on md_done.
- mem_wait arising in MD_WAIT: MEM_WAIT has priority for freeze outputs, but state stays MD_WAIT and md_done is latched internally if it arrives meanwhile.
- Branch (RUN, EX_BranchTaken, no higher event): IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1 for one cycle; overrides load-use stall in the same cycle.
- Load-use (RUN): ID_EX_MemRead & ID_EX_Write_register!=0 & ((UseRs1 & rs1==rd) | (UseRs2 & rs2==rd)) -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, one cycle; bubble guarantees no re-detection.
- Normal: all Write=1, Flushes=0, md_start=0.
- stall_count increments every cycle PC_Write=0 (post-reset), holds at all-ones.
- All outputs except md_error and stall_count are combinational from state and inputs; no cycle of latency added.

Decomposition:
- Shared package/header: state encodings (ST_RUN=2'd0, ST_MD_WAIT=2'd1, ST_MEM_WAIT=2'd2), x0 register constant.
- One natural sub-module: load_use_detect (pure combinational compare), reusable by later decode-stage checks. FSM and counters stay in hazard_controller.

Test Plan:
- lw x5 in EX (MemRead=1, rd=5), ID rs1=5 UseRs1=1 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle all normal; stall_count=1.
- Same with rd=0 -> no stall; with UseRs1=0 -> no stall.
- ID_EX_MulDiv=1, md_done after 5 cycles -> md_start high exactly cycle 0, holds 5 cycles, EX_MEM_Flush=1 during wait, EX_MEM_Write=1/Flush=0 on done cycle, no second md_start.
- MEM access with dmem_ready low 3 cycles -> all five Write enables 0 for 3 cycles, released on ready cycle; concurrent EX_BranchTaken ignored until release.
- EX_BranchTaken with simultaneous load-use -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
- MulDiv with md_done never asserted, MD_TIMEOUT=8 -> md_error=1 after 8 cycles, pipeline released; rst_n=0 mid-MD_WAIT -> state RUN, md_error=0, stall_count=0 next cycle.
